native_arbiter_2p: RTL

Two-to-one native-port arbiter downstream of wb2native. Merges two native user ports (p0, p1) onto the single native port of the controller core (m). Commands are round-robin arbitrated with first/last burst locking. Write data and read data are steered in command order through per-direction tag FIFOs.

---
 rtl/native_pkg.sv | 32 +++
 rtl/native_tag_fifo.sv | 76 +++++++
 rtl/native_arbiter_2p.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/native_pkg.sv
// Shared types and default widths for the native-port interconnect blocks.
package native_pkg;

    localparam int NATIVE_ADDR_W = 32;
    localparam int NATIVE_DATA_W = 256;

    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    typedef struct packed {
        logic                     first;
        logic                     last;
        logic                     we;
        logic [NATIVE_ADDR_W-1:0] addr;
    } native_cmd_t;

    typedef struct packed {
        logic                       first;
        logic                       last;
        logic [NATIVE_DATA_W-1:0]   data;
        logic [NATIVE_DATA_W/8-1:0] be;
    } native_wdata_t;

    typedef struct packed {
        logic                     first;
        logic                     last;
        logic [NATIVE_DATA_W-1:0] data;
    } native_rdata_t;

endpackage

// File: rtl/native_tag_fifo.sv
// One-bit-wide synchronous FIFO holding port ids in command order.
module native_tag_fifo
    import native_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  port_id_t din,
    input  logic     pop,
    output port_id_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    port_id_t        mem_reg [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic            full_reg;
    logic            full_next;
    logic            empty_reg;
    logic            empty_next;
    logic            do_push;
    logic            do_pop;

    // Full/empty are registered, so a pop in the same cycle never frees a slot for a push.
    always_comb begin
        do_push    = push & ~full_reg;
        do_pop     = pop & ~empty_reg;
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
        full_next  = (count_next == CW'(DEPTH));
        empty_next = (count_next == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
            full_reg  <= full_next;
            empty_reg <= empty_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    assign dout  = mem_reg[rd_ptr_reg];
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/native_arbiter_2p.sv
// Two-to-one native-port arbiter: round-robin command grant with burst locking,
// write/read data steered back to the issuing port in command order.
module native_arbiter_2p
    import native_pkg::*;
#(
    parameter int ADDR_W   = NATIVE_ADDR_W,
    parameter int DATA_W   = NATIVE_DATA_W,
    parameter int WR_DEPTH = 4,
    parameter int RD_DEPTH = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,

    input  logic                p0_cmd_valid,
    output logic                p0_cmd_ready,
    input  logic                p0_cmd_first,
    input  logic                p0_cmd_last,
    input  logic                p0_cmd_payload_we,
    input  logic [ADDR_W-1:0]   p0_cmd_payload_addr,
    input  logic                p0_wdata_valid,
    output logic                p0_wdata_ready,
    input  logic                p0_wdata_first,
    input  logic                p0_wdata_last,
    input  logic [DATA_W-1:0]   p0_wdata_payload_data,
    input  logic [DATA_W/8-1:0] p0_wdata_payload_we,
    output logic                p0_rdata_valid,
    input  logic                p0_rdata_ready,
    output logic                p0_rdata_first,
    output logic                p0_rdata_last,
    output logic [DATA_W-1:0]   p0_rdata_payload_data,

    input  logic                p1_cmd_valid,
    output logic                p1_cmd_ready,
    input  logic                p1_cmd_first,
    input  logic                p1_cmd_last,
    input  logic                p1_cmd_payload_we,
    input  logic [ADDR_W-1:0]   p1_cmd_payload_addr,
    input  logic                p1_wdata_valid,
    output logic                p1_wdata_ready,
    input  logic                p1_wdata_first,
    input  logic                p1_wdata_last,
    input  logic [DATA_W-1:0]   p1_wdata_payload_data,
    input  logic [DATA_W/8-1:0] p1_wdata_payload_we,
    output logic                p1_rdata_valid,
    input  logic                p1_rdata_ready,
    output logic                p1_rdata_first,
    output logic                p1_rdata_last,
    output logic [DATA_W-1:0]   p1_rdata_payload_data,

    output logic                m_cmd_valid,
    input  logic                m_cmd_ready,
    output logic                m_cmd_first,
    output logic                m_cmd_last,
    output logic                m_cmd_payload_we,
    output logic [ADDR_W-1:0]   m_cmd_payload_addr,
    output logic                m_wdata_valid,
    input  logic                m_wdata_ready,
    output logic                m_wdata_first,
    output logic                m_wdata_last,
    output logic [DATA_W-1:0]   m_wdata_payload_data,
    output logic [DATA_W/8-1:0] m_wdata_payload_we,
    input  logic                m_rdata_valid,
    output logic                m_rdata_ready,
    input  logic                m_rdata_first,
    input  logic                m_rdata_last,
    input  logic [DATA_W-1:0]   m_rdata_payload_data
);

    port_id_t   prio_reg, prio_next;
    port_id_t   lock_port_reg, lock_port_next;
    logic       lock_reg, lock_next;
    port_id_t   gnt;
    logic       gnt_full;
    logic       accept;
    logic [1:0] cmd_valid_vec;
    logic [1:0] cmd_ready_vec;
    logic [1:0] wdata_ready_vec;
    logic [1:0] rdata_valid_vec;
    logic [1:0] rdata_ready_vec;

    port_id_t   wr_head, rd_head;
    logic       wr_full, wr_empty, rd_full, rd_empty;
    logic       wr_push, rd_push, wr_pop, rd_pop;

    assign cmd_valid_vec   = {p1_cmd_valid, p0_cmd_valid};
    assign rdata_ready_vec = {p1_rdata_ready, p0_rdata_ready};

    always_comb begin
        gnt = prio_reg;
        if (lock_reg) begin
            gnt = lock_port_reg;
        end else if (cmd_valid_vec[prio_reg]) begin
            gnt = prio_reg;
        end else if (cmd_valid_vec[~prio_reg]) begin
            gnt = ~prio_reg;
        end
    end

    assign m_cmd_first        = gnt ? p1_cmd_first        : p0_cmd_first;
    assign m_cmd_last         = gnt ? p1_cmd_last         : p0_cmd_last;
    assign m_cmd_payload_we   = gnt ? p1_cmd_payload_we   : p0_cmd_payload_we;
    assign m_cmd_payload_addr = gnt ? p1_cmd_payload_addr : p0_cmd_payload_addr;

    // A full tag FIFO stalls the granted port; the other port does not get a turn instead.
    assign gnt_full    = m_cmd_payload_we ? wr_full : rd_full;
    assign m_cmd_valid = sys_rst_n & cmd_valid_vec[gnt] & ~gnt_full;
    assign accept      = m_cmd_valid & m_cmd_ready;

    always_comb begin
        prio_next      = prio_reg;
        lock_next      = lock_reg;
        lock_port_next = lock_port_reg;
        if (accept) begin
            if (m_cmd_last) begin
                lock_next = 1'b0;
                prio_next = ~gnt;
            end else begin
                lock_next      = 1'b1;
                lock_port_next = gnt;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            prio_reg      <= PORT0;
            lock_reg      <= 1'b0;
            lock_port_reg <= PORT0;
        end else begin
            prio_reg      <= prio_next;
            lock_reg      <= lock_next;
            lock_port_reg <= lock_port_next;
        end
    end

    assign wr_push = accept & m_cmd_payload_we;
    assign rd_push = accept & ~m_cmd_payload_we;

    native_tag_fifo #(.DEPTH(WR_DEPTH)) u_wr_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (wr_push),
        .din   (gnt),
        .pop   (wr_pop),
        .dout  (wr_head),
        .full  (wr_full),
        .empty (wr_empty)
    );

    native_tag_fifo #(.DEPTH(RD_DEPTH)) u_rd_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (rd_push),
        .din   (gnt),
        .pop   (rd_pop),
        .dout  (rd_head),
        .full  (rd_full),
        .empty (rd_empty)
    );

    assign m_wdata_valid        = sys_rst_n & ~wr_empty & (wr_head ? p1_wdata_valid : p0_wdata_valid);
    assign m_wdata_first        = wr_head ? p1_wdata_first        : p0_wdata_first;
    assign m_wdata_last         = wr_head ? p1_wdata_last         : p0_wdata_last;
    assign m_wdata_payload_data = wr_head ? p1_wdata_payload_data : p0_wdata_payload_data;
    assign m_wdata_payload_we   = wr_head ? p1_wdata_payload_we   : p0_wdata_payload_we;
    assign wr_pop               = m_wdata_valid & m_wdata_ready;

    assign m_rdata_ready = sys_rst_n & ~rd_empty & rdata_ready_vec[rd_head];
    assign rd_pop        = m_rdata_valid & m_rdata_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign cmd_ready_vec[gi]   = sys_rst_n & ~gnt_full & (gnt == port_id_t'(gi)) & m_cmd_ready;
            assign wdata_ready_vec[gi] = sys_rst_n & ~wr_empty & (wr_head == port_id_t'(gi)) & m_wdata_ready;
            assign rdata_valid_vec[gi] = sys_rst_n & ~rd_empty & (rd_head == port_id_t'(gi)) & m_rdata_valid;
        end
    endgenerate

    assign p0_cmd_ready   = cmd_ready_vec[0];
    assign p1_cmd_ready   = cmd_ready_vec[1];
    assign p0_wdata_ready = wdata_ready_vec[0];
    assign p1_wdata_ready = wdata_ready_vec[1];
    assign p0_rdata_valid = rdata_valid_vec[0];
    assign p1_rdata_valid = rdata_valid_vec[1];

    assign p0_rdata_first        = m_rdata_first;
    assign p0_rdata_last         = m_rdata_last;
    assign p0_rdata_payload_data = m_rdata_payload_data;
    assign p1_rdata_first        = m_rdata_first;
    assign p1_rdata_last         = m_rdata_last;
    assign p1_rdata_payload_data = m_rdata_payload_data;

endmodule
